reflet_8bit_bootloader: RTL

//  UART boot loader sitting upstream of the 8-bit controller. It holds the CPU
//  in reset and receives a framed program over rx. It writes the program bytes into

---
 rtl/reflet_8bit_bootloader_pkg.sv | 22 ++
 rtl/reflet_boot_uart_rx.sv | 98 +++++++++
 rtl/reflet_8bit_bootloader.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/reflet_8bit_bootloader_pkg.sv
// Shared constants and state encodings for the 8-bit controller UART boot loader.
package reflet_8bit_bootloader_pkg;

    localparam logic [7:0] BOOT_MAGIC = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_SUM  = 3'd3,
        S_ERR  = 3'd4,
        S_DONE = 3'd5
    } boot_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/reflet_boot_uart_rx.sv
// UART 8N1 receiver: 2-flop synchronizer, half-bit start check, mid-bit sampling.
module reflet_boot_uart_rx
    import reflet_8bit_bootloader_pkg::*;
#(
    parameter int clk_freq  = 1000000,
    parameter int baud_rate = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic [1:0] dbg_state
);

    localparam int DIV = clk_freq / baud_rate;
    localparam int CW  = $clog2(DIV + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          rx_meta_q, rx_sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!rx_sync_q) state_d = RX_START;
            end
            RX_START: begin
                // A start that is no longer low at mid-bit is treated as a glitch.
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    valid_d = rx_sync_q;
                    ferr_d  = !rx_sync_q;
                    state_d = RX_IDLE;
                end
            end
        endcase
    end

    // valid and frame_err are mutually exclusive single-cycle pulses; data is
    // stable while valid is high. There is no ready: the consumer must take it.
    assign data      = shift_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign dbg_state = state_q;

endmodule

// File: rtl/reflet_8bit_bootloader.sv
// Boot loader: receives A5/LEN/data/CHK over UART, writes instruction RAM, releases CPU.
module reflet_8bit_bootloader
    import reflet_8bit_bootloader_pkg::*;
#(
    parameter int clk_freq      = 1000000,
    parameter int baud_rate     = 9600,
    parameter int mem_size      = 128,
    parameter int timeout_bytes = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       bypass,
    output logic [6:0] mem_addr,
    output logic [7:0] mem_data,
    output logic       mem_write_en,
    output logic       cpu_hold,
    output logic       load_done,
    output logic       load_error,
    output logic [2:0] dbg_state,
    output logic [1:0] dbg_rx_state
);

    localparam int DIV       = clk_freq / baud_rate;
    localparam int TMO_LIMIT = timeout_bytes * 10 * DIV;
    localparam int TW        = $clog2(TMO_LIMIT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_LIMIT - 1);
    localparam logic [7:0]    MEM_MAX  = 8'(mem_size);

    logic [7:0] rx_data;
    logic       rx_valid, rx_frame_err;

    reflet_boot_uart_rx #(
        .clk_freq  (clk_freq),
        .baud_rate (baud_rate)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .data      (rx_data),
        .valid     (rx_valid),
        .frame_err (rx_frame_err),
        .dbg_state (dbg_rx_state)
    );

    boot_state_t   state_q, state_d;
    logic [7:0]    count_q, count_d;
    logic [6:0]    addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic          we_q, we_d;
    logic [7:0]    sum_q, sum_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          hold_q, hold_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            sum_q   <= '0;
            tmo_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            sum_q   <= sum_d;
            tmo_q   <= tmo_d;
            done_q  <= done_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        sum_d   = sum_q;
        tmo_d   = '0;
        done_d  = done_q;
        err_d   = err_q;
        hold_d  = hold_q;
        // Address and checksum advance in the cycle after each write strobe.
        if (we_q) begin
            addr_d = addr_q + 7'd1;
            sum_d  = sum_q + data_q;
        end
        case (state_q)
            S_IDLE: begin
                if (bypass) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    hold_d  = 1'b0;
                end else if (rx_valid && rx_data == BOOT_MAGIC) begin
                    state_d = S_LEN;
                    err_d   = 1'b0;
                end
            end
            S_LEN, S_DATA, S_SUM: begin
                tmo_d = tmo_q + 1'b1;
                if (rx_valid) begin
                    tmo_d = '0;
                    if (state_q == S_LEN) begin
                        if (rx_data == 8'd0 || rx_data > MEM_MAX) begin
                            state_d = S_ERR;
                        end else begin
                            count_d = rx_data;
                            addr_d  = '0;
                            sum_d   = '0;
                            state_d = S_DATA;
                        end
                    end else if (state_q == S_DATA) begin
                        data_d  = rx_data;
                        we_d    = 1'b1;
                        count_d = count_q - 8'd1;
                        if (count_q == 8'd1) state_d = S_SUM;
                    end else if (rx_data == sum_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = S_ERR;
                    end
                end else if (rx_frame_err || tmo_q == TMO_LAST) begin
                    state_d = S_ERR;
                end
            end
            S_ERR: begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end
            S_DONE: begin
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_addr     = addr_q;
    assign mem_data     = data_q;
    assign mem_write_en = we_q;
    assign cpu_hold     = hold_q;
    assign load_done    = done_q;
    assign load_error   = err_q;
    assign dbg_state    = state_q;

endmodule
